// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx
//   Receives a 4-wire LCD SPI stream (lcd_clk/lcd_cs/lcd_rs/lcd_data),
//   reassembles bytes and decodes the minimal command set of an LCD
//   controller: CASET/RASET windowing, RAMWR pixel streaming with an
//   auto-advancing pointer, and the sleep / display on-off commands.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   lcd_clk, lcd_cs   SPI clock (async to clk) and active-low chip select
//   lcd_rs, lcd_data  data/command select and MSB-first serial data
//   byte_valid/data/rs  one pulse per received byte with its rs flag
//   pix_valid/data/x/y  one pulse per completed RGB565 pixel with address
//   sleep_out, disp_on  controller status flags

module lcd_spi_rx #(
    parameter int unsigned XE_RST = 239,
    parameter int unsigned YE_RST = 319
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_clk,
    input  logic        lcd_cs,
    input  logic        lcd_rs,
    input  logic        lcd_data,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_rs,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        sleep_out,
    output logic        disp_on
);

    localparam logic [8:0] XE_INIT = XE_RST[8:0];
    localparam logic [8:0] YE_INIT = YE_RST[8:0];

    typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, OTHER} state_t;

    // ---------------------------------------------------------------
    // Input synchronizers and serial byte assembly
    // ---------------------------------------------------------------
    logic [1:0] clk_sync, cs_sync, rs_sync, dat_sync;
    logic       clk_prev;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '0;
            cs_sync  <= '0;
            rs_sync  <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], lcd_clk};
            cs_sync  <= {cs_sync[0], lcd_cs};
            rs_sync  <= {rs_sync[0], lcd_rs};
            dat_sync <= {dat_sync[0], lcd_data};
            clk_prev <= clk_sync[1];
        end
    end

    logic       sclk_rise;
    logic       byte_done;
    logic [7:0] new_byte;
    logic       new_rs;

    assign sclk_rise = clk_sync[1] & ~clk_prev;
    assign byte_done = sclk_rise & ~cs_sync[1] & (bit_cnt == 3'd7);
    assign new_byte  = {shreg[6:0], dat_sync[1]};
    assign new_rs    = rs_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (cs_sync[1]) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            shreg   <= new_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_rs    <= 1'b0;
        end else begin
            byte_valid <= byte_done;
            if (byte_done) begin
                byte_data <= new_byte;
                byte_rs   <= new_rs;
            end
        end
    end

    // ---------------------------------------------------------------
    // Command decoder FSM
    // ---------------------------------------------------------------
    state_t state, next_state;

    logic is_cmd, is_dat;
    assign is_cmd = byte_done & ~new_rs;
    assign is_dat = byte_done & new_rs;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (is_cmd) begin
            case (new_byte)
                8'h2A:   next_state = CASET;
                8'h2B:   next_state = RASET;
                8'h2C:   next_state = RAMWR;
                default: next_state = OTHER;
            endcase
        end
    end

    logic [2:0] pidx;       // parameter byte index, saturates at 4
    logic       pix_phase;  // 1 when a pixel high byte is pending
    logic       ld_ptr, prm_wr, prm_last, pix_hi_wr, pix_done;

    always_comb begin
        ld_ptr    = 1'b0;
        prm_wr    = 1'b0;
        prm_last  = 1'b0;
        pix_hi_wr = 1'b0;
        pix_done  = 1'b0;
        if (is_cmd && new_byte == 8'h2C)
            ld_ptr = 1'b1;
        if (is_dat && (state == CASET || state == RASET) && !pidx[2]) begin
            prm_wr   = 1'b1;
            prm_last = (pidx == 3'd3);
        end
        if (is_dat && state == RAMWR) begin
            pix_hi_wr = ~pix_phase;
            pix_done  = pix_phase;
        end
    end

    // ---------------------------------------------------------------
    // Window registers
    // ---------------------------------------------------------------
    // Only address bit 8 of each high byte matters, so only that bit is kept.
    logic       p0_b8, p2_b8;
    logic [7:0] p1;
    logic [8:0] xs, xe, ys, ye;

    always_ff @(posedge clk) begin
        if (reset) begin
            pidx  <= '0;
            p0_b8 <= 1'b0;
            p1    <= '0;
            p2_b8 <= 1'b0;
            xs    <= '0;
            xe    <= XE_INIT;
            ys    <= '0;
            ye    <= YE_INIT;
        end else begin
            if (is_cmd)
                pidx <= '0;
            else if (prm_wr)
                pidx <= pidx + 3'd1;
            if (prm_wr) begin
                case (pidx[1:0])
                    2'd0:    p0_b8 <= new_byte[0];
                    2'd1:    p1    <= new_byte;
                    2'd2:    p2_b8 <= new_byte[0];
                    default: ;
                endcase
            end
            if (prm_last) begin
                if (state == CASET) begin
                    xs <= {p0_b8, p1};
                    xe <= {p2_b8, new_byte};
                end else begin
                    ys <= {p0_b8, p1};
                    ye <= {p2_b8, new_byte};
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Pixel assembly and write pointer
    // ---------------------------------------------------------------
    logic [7:0] pix_hi;
    logic [8:0] ptr_x, ptr_y, nxt_x, nxt_y;

    // Wrap is an equality test, so a window with start > end still wraps
    // once the pointer counts (mod 512) up to the end address.
    always_comb begin
        nxt_x = ptr_x + 9'd1;
        nxt_y = ptr_y;
        if (ptr_x == xe) begin
            nxt_x = xs;
            nxt_y = (ptr_y == ye) ? ys : ptr_y + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_phase <= 1'b0;
            pix_hi    <= '0;
            ptr_x     <= '0;
            ptr_y     <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            pix_valid <= pix_done;
            if (is_cmd) begin
                pix_phase <= 1'b0;
            end else if (pix_hi_wr) begin
                pix_phase <= 1'b1;
                pix_hi    <= new_byte;
            end else if (pix_done) begin
                pix_phase <= 1'b0;
            end
            if (ld_ptr) begin
                ptr_x <= xs;
                ptr_y <= ys;
            end else if (pix_done) begin
                ptr_x <= nxt_x;
                ptr_y <= nxt_y;
            end
            if (pix_done) begin
                pix_data <= {pix_hi, new_byte};
                pix_x    <= ptr_x;
                pix_y    <= ptr_y;
            end
        end
    end

    // ---------------------------------------------------------------
    // Status flags
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sleep_out <= 1'b0;
            disp_on   <= 1'b0;
        end else if (is_cmd) begin
            case (new_byte)
                8'h11:   sleep_out <= 1'b1;
                8'h10:   sleep_out <= 1'b0;
                8'h29:   disp_on   <= 1'b1;
                8'h28:   disp_on   <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 Parameter XE_RST, default 239, reset value of column end address.
REQ-002 Parameter YE_RST, default 319, reset value of row end address.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lcd_clk  input  1  serial clock from LCD master, asynchronous to clk.
REQ-006 lcd_cs  input  1  chip select, active low.
REQ-007 lcd_rs  input  1  data/command select (0 = command, 1 = data).
REQ-008 lcd_data  input  1  serial data, MSB first.
REQ-009 byte_valid  output  1  one-cycle pulse per received byte.
REQ-010 byte_data  output  8  received byte, valid with byte_valid.
REQ-011 byte_rs  output  1  lcd_rs captured with the byte's 8th bit.
REQ-012 pix_valid  output  1  one-cycle pulse per completed RAMWR pixel.
REQ-013 pix_data  output  16  RGB565 pixel, first byte in [15:8].
REQ-014 pix_x  output  9  column address of pix_data.
REQ-015 pix_y  output  9  row address of pix_data.
REQ-016 sleep_out  output  1  set by command 0x11, cleared by 0x10.
REQ-017 disp_on  output  1  set by command 0x29, cleared by 0x28.

Function
REQ-018 lcd_clk, lcd_cs, lcd_rs and lcd_data shall each pass through a 2-flop synchronizer before use.
REQ-019 The block shall detect a lcd_clk rising edge when the synchronized lcd_clk value is 1 and its previous value was 0.
REQ-020 The block shall support lcd_clk high and low phases of at least 2 clk cycles each.
REQ-021 On each lcd_clk rising edge with lcd_cs low, the block shall shift lcd_data into an 8-bit register, MSB first, and increment a 3-bit bit counter.
REQ-022 On the 8th bit, the block shall pulse byte_valid one cycle after that edge is detected, with byte_rs equal to lcd_rs sampled on the same edge.
REQ-023 lcd_cs high shall clear the bit counter; a partial byte shall be discarded and produce no byte_valid.
REQ-024 Decoder states shall be IDLE, CASET, RASET, RAMWR and OTHER.
REQ-025 A command byte (rs=0) shall select the state from any state: 0x2A to CASET, 0x2B to RASET, 0x2C to RAMWR, any other code to OTHER, and shall clear the parameter index.
REQ-026 CASET shall take 4 data bytes in the order XS[15:8], XS[7:0], XE[15:8], XE[7:0], and shall store bits [8:0] of each address.
REQ-027 XS and XE shall update only after the 4th byte, and bytes beyond the 4th shall be ignored.
REQ-028 RASET shall behave as CASET for YS and YE.
REQ-029 Entering RAMWR shall set the write pointer to (XS, YS) and clear the pixel byte phase.
REQ-030 In RAMWR, each even-numbered data byte shall be held as the pixel high byte.
REQ-031 In RAMWR, each odd-numbered data byte shall complete a pixel: pix_valid pulses in the same cycle as that byte's byte_valid, with pix_x and pix_y equal to the current pointer.
REQ-032 After each pixel, the pointer shall advance x; at x == XE, x wraps to XS and y advances.
REQ-033 At x == XE and y == YE together, the pointer shall wrap to (XS, YS).
REQ-034 If XS > XE, the pointer shall still wrap when x equals XE; x otherwise increments mod 512. The same rule applies to y.
REQ-035 A command arriving with a pending high byte shall discard that byte and produce no pixel.
REQ-036 A CASET or RASET received mid-frame shall take effect only at the next 0x2C.
REQ-037 Data bytes in IDLE or OTHER shall produce only byte_valid.
REQ-038 The commands 0x11, 0x10, 0x29 and 0x28 shall update sleep_out and disp_on in the cycle of their byte_valid.

Reset
REQ-039 While reset is high, all synchronizers, the shift register and the bit counter shall clear.
REQ-040 While reset is high, byte_valid, pix_valid, sleep_out and disp_on shall be 0.
REQ-041 On reset, byte_data, byte_rs, pix_data, pix_x and pix_y shall be 0.
REQ-042 On reset, state = IDLE, XS = YS = 0, XE = XE_RST, YE = YE_RST.
REQ-043 Reset asserted mid-byte or mid-pixel shall discard partial data, and no pulse shall follow its release.

Verification
REQ-044 Send rs=0 byte 0x11 with an SCLK period of 4 clk -> one byte_valid, byte_data = 0x11, byte_rs = 0, sleep_out = 1.
REQ-045 Send 0x2A 00 28 01 17, then 0x2B 00 35 00 BB, then 0x2C with pixels F034 and 0000 -> pix (0x028,0x035) = F034, then (0x029,0x035) = 0000.
REQ-046 Use window XS = XE = 5 and YS = 2, YE = 3, then send 3 pixels -> pixel addresses (5,2), (5,3), (5,2).
REQ-047 Raise lcd_cs after 5 bits, then send a full byte 0xA5 -> exactly one byte_valid, with byte_data = 0xA5.
REQ-048 During 0x2C, send a single byte 0xAB, then command 0x29 -> no pix_valid, disp_on = 1.
REQ-049 Assert reset after 3 pixel bytes, then release it and send 0x2C plus 1 pixel -> pixel at (0,0) and XE = 239.
